// File: rtl/disto_nxn_accum.sv
// Weighted TTransform distortion of an NxN block, computed as a stream of 4x4 sub-blocks through one pipelined core.
// Optional per-sub-block result outputs are enabled with `define DISTO_SUBBLK_OUT_EN.

// Pipelined 4x4 distortion core: |TTransform(b,w) - TTransform(a,w)| >> 5, latency 3 cycles.
module disto4x4_core (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [127:0]        a,
    input  logic [127:0]        b,
    input  logic [255:0]        w,
    output logic                done,
    output logic signed [31:0]  sum
);

    logic         v1, v2;
    logic [127:0] a1, b1;
    logic [255:0] w1;
    logic [31:0]  ta, tb;

    // Worst case 16 * 4080 * 65535 still fits in 32 unsigned bits.
    function automatic logic [31:0] ttransform(input logic [127:0] px, input logic [255:0] wt);
        logic signed [12:0] p   [16];
        logic signed [12:0] tmp [16];
        logic signed [12:0] bv  [4];
        logic signed [12:0] a0, a1s, a2, a3;
        logic [11:0]        mag;
        logic [31:0]        acc;
        acc = '0;
        for (int k = 0; k < 16; k++) p[k] = $signed({5'd0, px[8*k +: 8]});
        for (int i = 0; i < 4; i++) begin
            a0  = p[4*i]   + p[4*i+2];
            a1s = p[4*i+1] + p[4*i+3];
            a2  = p[4*i+1] - p[4*i+3];
            a3  = p[4*i]   - p[4*i+2];
            tmp[4*i]   = a0 + a1s;
            tmp[4*i+1] = a3 + a2;
            tmp[4*i+2] = a3 - a2;
            tmp[4*i+3] = a0 - a1s;
        end
        for (int i = 0; i < 4; i++) begin
            a0  = tmp[i]   + tmp[8+i];
            a1s = tmp[4+i] + tmp[12+i];
            a2  = tmp[4+i] - tmp[12+i];
            a3  = tmp[i]   - tmp[8+i];
            bv[0] = a0 + a1s;
            bv[1] = a3 + a2;
            bv[2] = a3 - a2;
            bv[3] = a0 - a1s;
            for (int j = 0; j < 4; j++) begin
                mag = bv[j][12] ? 12'(-bv[j]) : 12'(bv[j]);
                acc = acc + 32'(mag) * 32'(wt[16*(i+4*j) +: 16]);
            end
        end
        return acc;
    endfunction

    function automatic logic [31:0] abs_diff_shr5(input logic [31:0] s1, input logic [31:0] s2);
        logic signed [32:0] d;
        logic [32:0]        m;
        d = $signed({1'b0, s2}) - $signed({1'b0, s1});
        m = d[32] ? 33'(-d) : 33'(d);
        return 32'(m >> 5);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            done <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            w1   <= '0;
            ta   <= '0;
            tb   <= '0;
            sum  <= '0;
        end else begin
            v1   <= start;
            v2   <= v1;
            done <= v2;
            if (start) begin
                a1 <= a;
                b1 <= b;
                w1 <= w;
            end
            if (v1) begin
                ta <= ttransform(a1, w1);
                tb <= ttransform(b1, w1);
            end
            if (v2) sum <= $signed(abs_diff_shr5(ta, tb));
        end
    end

endmodule

module disto_nxn_accum #(
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned NSUB       = (BLOCK_SIZE/4)**2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    ina,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    inb,
    input  logic [255:0]                          w,
    output logic                                  busy,
    output logic signed [31:0]                    sum,
    output logic                                  done
`ifdef DISTO_SUBBLK_OUT_EN
    ,
    output logic                                  sub_valid,
    output logic [((NSUB>1)?$clog2(NSUB):1)-1:0]  sub_idx,
    output logic signed [31:0]                    sub_sum
`endif
);

    localparam int unsigned PW = 8*BLOCK_SIZE*BLOCK_SIZE;
    localparam int unsigned SB = BLOCK_SIZE/4;
    localparam int unsigned CW = $clog2(NSUB) + 1;
    localparam int unsigned IW = (NSUB > 1) ? $clog2(NSUB) : 1;

    if (!(BLOCK_SIZE == 4 || BLOCK_SIZE == 8 || BLOCK_SIZE == 16 || BLOCK_SIZE == 32)) begin : g_bad_size
        $error("disto_nxn_accum: BLOCK_SIZE must be 4, 8, 16 or 32");
    end
    if (BIT_WIDTH != 8) begin : g_bad_width
        $error("disto_nxn_accum: BIT_WIDTH must be 8");
    end
    if (NSUB != SB*SB) begin : g_bad_nsub
        $error("disto_nxn_accum: NSUB is derived and must not be overridden");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       a_q, b_q;
    logic [255:0]        w_q;
    logic [CW-1:0]       iss_cnt, ret_cnt;
    logic                start_acc;
    logic                core_start;
    logic [127:0]        op_a, op_b;
    logic                core_done;
    logic signed [31:0]  core_sum;
    logic                last_ret;

    assign start_acc  = start && (state == ST_IDLE);
    assign core_start = (state == ST_ISSUE);
    assign last_ret   = core_done && (ret_cnt == CW'(NSUB-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The final core return may coincide with the last issue cycle, so DONE is reachable from ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: if (iss_cnt == CW'(NSUB-1)) state_nxt = last_ret ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (ret_cnt == CW'(NSUB) || last_ret) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Select the current 4x4 sub-block in raster order and pack it row-wise, x0 in the LSBs.
    always_comb begin
        int unsigned k, kr, kc;
        op_a = '0;
        op_b = '0;
        k  = 32'(iss_cnt) % NSUB;
        kr = k / SB;
        kc = k % SB;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                op_a[32*y + 8*x +: 8] = a_q[8*((4*kr + y)*BLOCK_SIZE + 4*kc + x) +: 8];
                op_b[32*y + 8*x +: 8] = b_q[8*((4*kr + y)*BLOCK_SIZE + 4*kc + x) +: 8];
            end
        end
    end

    disto4x4_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .a     (op_a),
        .b     (op_b),
        .w     (w_q),
        .done  (core_done),
        .sum   (core_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
            sum     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
            if (start_acc) begin
                a_q     <= ina;
                b_q     <= inb;
                w_q     <= w;
                iss_cnt <= '0;
                ret_cnt <= '0;
                sum     <= '0;
            end else begin
                if (state == ST_ISSUE) iss_cnt <= iss_cnt + CW'(1);
                if (core_done && state != ST_IDLE) begin
                    sum     <= sum + core_sum;
                    ret_cnt <= ret_cnt + CW'(1);
                end
            end
        end
    end

`ifdef DISTO_SUBBLK_OUT_EN
    // Core results return in issue order, so the return counter is the sub-block index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_valid <= 1'b0;
            sub_idx   <= '0;
            sub_sum   <= '0;
        end else begin
            sub_valid <= core_done && (state != ST_IDLE);
            if (core_done && state != ST_IDLE) begin
                sub_idx <= IW'(ret_cnt);
                sub_sum <= core_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_disto_nxn_accum.sv
// Directed bench for disto_nxn_accum at BLOCK_SIZE 4/8/16/32 against a reference distortion model.
module tb_disto_nxn_accum;

    localparam int L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [3:0]         start_v, busy_v, done_v;
    logic signed [31:0] sum_v [4];
    logic [127:0]       ina4, inb4;
    logic [511:0]       ina8, inb8;
    logic [2047:0]      ina16, inb16;
    logic [8191:0]      ina32, inb32;
    logic [255:0]       w;
`ifdef DISTO_SUBBLK_OUT_EN
    logic [3:0]         sv_v;
    logic [0:0]         si4;
    logic [1:0]         si8;
    logic [3:0]         si16;
    logic [5:0]         si32;
    logic signed [31:0] ss_v [4];
`endif

    disto_nxn_accum #(.BLOCK_SIZE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ina(ina4), .inb(inb4), .w(w),
        .busy(busy_v[0]), .sum(sum_v[0]), .done(done_v[0])
`ifdef DISTO_SUBBLK_OUT_EN
        , .sub_valid(sv_v[0]), .sub_idx(si4), .sub_sum(ss_v[0])
`endif
    );
    disto_nxn_accum #(.BLOCK_SIZE(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ina(ina8), .inb(inb8), .w(w),
        .busy(busy_v[1]), .sum(sum_v[1]), .done(done_v[1])
`ifdef DISTO_SUBBLK_OUT_EN
        , .sub_valid(sv_v[1]), .sub_idx(si8), .sub_sum(ss_v[1])
`endif
    );
    disto_nxn_accum #(.BLOCK_SIZE(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .ina(ina16), .inb(inb16), .w(w),
        .busy(busy_v[2]), .sum(sum_v[2]), .done(done_v[2])
`ifdef DISTO_SUBBLK_OUT_EN
        , .sub_valid(sv_v[2]), .sub_idx(si16), .sub_sum(ss_v[2])
`endif
    );
    disto_nxn_accum #(.BLOCK_SIZE(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .ina(ina32), .inb(inb32), .w(w),
        .busy(busy_v[3]), .sum(sum_v[3]), .done(done_v[3])
`ifdef DISTO_SUBBLK_OUT_EN
        , .sub_valid(sv_v[3]), .sub_idx(si32), .sub_sum(ss_v[3])
`endif
    );

    int tot = 0;
    int bad = 0;
    int pa [1024];
    int pb [1024];
    int wt [16];

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference TTransform of one 4x4 tile of block A or B (pixel arrays use a 32-pixel stride).
    function automatic longint tt(input bit use_b, input int r, input int c);
        longint px [4][4];
        longint tmp [16];
        longint a0, a1, a2, a3, bb [4], s;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                px[y][x] = use_b ? longint'(pb[(4*r+y)*32 + 4*c + x]) : longint'(pa[(4*r+y)*32 + 4*c + x]);
        for (int i = 0; i < 4; i++) begin
            a0 = px[i][0] + px[i][2];
            a1 = px[i][1] + px[i][3];
            a2 = px[i][1] - px[i][3];
            a3 = px[i][0] - px[i][2];
            tmp[4*i] = a0 + a1; tmp[4*i+1] = a3 + a2; tmp[4*i+2] = a3 - a2; tmp[4*i+3] = a0 - a1;
        end
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = tmp[i] + tmp[8+i];
            a1 = tmp[4+i] + tmp[12+i];
            a2 = tmp[4+i] - tmp[12+i];
            a3 = tmp[i] - tmp[8+i];
            bb[0] = a0 + a1; bb[1] = a3 + a2; bb[2] = a3 - a2; bb[3] = a0 - a1;
            for (int j = 0; j < 4; j++)
                s += longint'(wt[i + 4*j]) * ((bb[j] < 0) ? -bb[j] : bb[j]);
        end
        return s;
    endfunction

    function automatic int model(input int n);
        int sb, total;
        longint d;
        sb = n / 4;
        total = 0;
        for (int k = 0; k < sb*sb; k++) begin
            d = tt(1'b1, k / sb, k % sb) - tt(1'b0, k / sb, k % sb);
            if (d < 0) d = -d;
            total += int'(d >>> 5);
        end
        return total;
    endfunction

    task automatic pack(input int sel);
        int n;
        n = 4 << sel;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                case (sel)
                    0: begin ina4[8*(y*n+x) +: 8]  = 8'(pa[y*32+x]); inb4[8*(y*n+x) +: 8]  = 8'(pb[y*32+x]); end
                    1: begin ina8[8*(y*n+x) +: 8]  = 8'(pa[y*32+x]); inb8[8*(y*n+x) +: 8]  = 8'(pb[y*32+x]); end
                    2: begin ina16[8*(y*n+x) +: 8] = 8'(pa[y*32+x]); inb16[8*(y*n+x) +: 8] = 8'(pb[y*32+x]); end
                    default: begin ina32[8*(y*n+x) +: 8] = 8'(pa[y*32+x]); inb32[8*(y*n+x) +: 8] = 8'(pb[y*32+x]); end
                endcase
        for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'(wt[j]);
    endtask

    task automatic rand_data(input bit same);
        for (int i = 0; i < 1024; i++) begin
            pa[i] = int'($urandom_range(0, 255));
            pb[i] = same ? pa[i] : int'($urandom_range(0, 255));
        end
        for (int j = 0; j < 16; j++) wt[j] = int'($urandom_range(0, 65535));
    endtask

    // One request on instance sel; optional extra starts while busy and in the done cycle.
    task automatic run(input int sel, input string tag, input int exp_sum, input bit restart);
        int nsub, exp_done, busy_cnt, done_cyc, done_cnt;
        nsub = ((4 << sel) / 4) ** 2;
        exp_done = nsub + L + 1;
        busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        @(posedge clk); #1;
        start_v[sel] = 1'b1;
        for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
            @(posedge clk); #1;
            start_v[sel] = 1'b0;
            if (busy_v[sel]) busy_cnt++;
            if (done_v[sel]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, "_sum_at_done"}, sum_v[sel], exp_sum);
                end
            end
            if (restart && (cyc == 3 || cyc == exp_done)) begin
                rand_data(1'b0);
                pack(sel);
                start_v[sel] = 1'b1;
            end
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done);
        check({tag, "_sum_held"}, sum_v[sel], exp_sum);
    endtask

`ifdef DISTO_SUBBLK_OUT_EN
    int sub_n8 = 0;
    int sub_acc8 = 0;
    always @(negedge clk) begin
        if (rst_n && sv_v[1]) begin
            check("sub_idx8", si8, sub_n8 % 4);
            sub_n8++;
            sub_acc8 += ss_v[1];
        end
    end
`endif

    initial begin
        int exp, s4;
        rst_n = 1'b0;
        start_v = '0;
        ina4 = '0; inb4 = '0; ina8 = '0; inb8 = '0;
        ina16 = '0; inb16 = '0; ina32 = '0; inb32 = '0; w = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst_busy%0d", s), busy_v[s], 0);
            check($sformatf("rst_done%0d", s), done_v[s], 0);
            check($sformatf("rst_sum%0d", s), sum_v[s], 0);
        end
        @(negedge clk) rst_n = 1'b1;

        // Identical blocks give zero distortion.
        rand_data(1'b1); pack(2);
        run(2, "eq16", 0, 1'b0);

        // One 200 pixel at each tile origin, unit weights: 16*200 >> 5 = 100 per tile.
        for (int i = 0; i < 1024; i++) begin pa[i] = 0; pb[i] = 0; end
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pb[(4*r)*32 + 4*c] = 200;
        for (int j = 0; j < 16; j++) wt[j] = 1;
        pack(0); pack(1); pack(2);
        run(0, "dc4", 100, 1'b0);
        run(1, "dc8", 400, 1'b0);
        run(2, "dc16", 1600, 1'b0);

        // Same random tile P/Q repeated across 16x16.
        rand_data(1'b0);
        for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) begin
            pa[y*32+x] = pa[(y%4)*32 + (x%4)];
            pb[y*32+x] = pb[(y%4)*32 + (x%4)];
        end
        s4 = model(4);
        pack(0); pack(2);
        run(0, "pq4", s4, 1'b0);
        run(2, "pq16", 16*s4, 1'b0);

        rand_data(1'b0); pack(0); exp = model(4);
        run(0, "rnd4", exp, 1'b0);
        rand_data(1'b0); pack(1); exp = model(8);
`ifdef DISTO_SUBBLK_OUT_EN
        sub_n8 = 0; sub_acc8 = 0;
`endif
        run(1, "rnd8", exp, 1'b0);
`ifdef DISTO_SUBBLK_OUT_EN
        check("sub_count8", sub_n8, 4);
        check("sub_total8", sub_acc8, exp);
`endif
        rand_data(1'b0); pack(3); exp = model(32);
        run(3, "rnd32", exp, 1'b0);

        // Starts while busy and in the done cycle must be ignored.
        rand_data(1'b0); pack(2); exp = model(16);
        run(2, "restart", exp, 1'b1);

        // Asynchronous reset in the middle of a 16x16 run.
        rand_data(1'b0); pack(2);
        @(posedge clk); #1;
        start_v[2] = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            start_v[2] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_sum", sum_v[2], 0);
        check("midrst_busy", busy_v[2], 0);
        check("midrst_done", done_v[2], 0);
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        rand_data(1'b0); pack(2); exp = model(16);
        run(2, "after_rst", exp, 1'b0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
